// File: rtl/dsp_mac_stream_if.sv
// Operand/result stream bundle for dsp_mac_stream.
// The master drives operands and consumes results; the slave is the MAC engine.
interface dsp_mac_stream_if #(
  parameter int AW    = 18,
  parameter int BW    = 18,
  parameter int PW    = 48,
  parameter int LEN_W = 8
);
  logic                    CE;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [AW-1:0]    A;
  logic signed [BW-1:0]    B;
  logic signed [BW-1:0]    D;
  logic        [1:0]       MODE;
  logic        [LEN_W-1:0] LEN;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [PW-1:0]    P;
  logic                    OVF;

  modport master (
    output CE, in_valid, A, B, D, MODE, LEN, out_ready,
    input  in_ready, out_valid, P, OVF
  );

  modport slave (
    input  CE, in_valid, A, B, D, MODE, LEN, out_ready,
    output in_ready, out_valid, P, OVF
  );
endinterface

// File: rtl/dsp_mac_stream.sv
// Streaming pre-add / multiply / accumulate engine reducing LEN-beat frames to one
// dot-product result, with a whole-pipe stall on output backpressure.
module dsp_mac_stream #(
  parameter int AW       = 18,
  parameter int BW       = 18,
  parameter int PW       = 48,
  parameter int LEN_W    = 8,
  parameter bit SATURATE = 1'b0
) (
  input logic            CLK,
  input logic            RST,
  dsp_mac_stream_if.slave bus
);
  localparam int MW = AW + BW + 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  function automatic logic signed [BW:0] f_pre(input logic [1:0] mode,
                                               input logic signed [BW-1:0] b,
                                               input logic signed [BW-1:0] d);
    logic signed [BW:0] bx, dx;
    bx = {b[BW-1], b};
    dx = {d[BW-1], d};
    case (mode)
      2'b01:   return dx + bx;
      2'b10:   return dx - bx;
      default: return bx;
    endcase
  endfunction

  // Any PW+1 sum whose top two bits disagree is out of PW range.
  function automatic logic signed [PW-1:0] f_sat(input logic signed [PW:0] s);
    logic signed [PW-1:0] max_v, min_v;
    max_v = {1'b0, {(PW-1){1'b1}}};
    min_v = {1'b1, {(PW-1){1'b0}}};
    if (SATURATE && (s[PW] != s[PW-1])) return s[PW] ? min_v : max_v;
    return s[PW-1:0];
  endfunction

  state_t                r_state, w_nxt_state;
  logic [LEN_W-1:0]      r_cnt, w_nxt_cnt, r_len, w_nxt_len, w_len_eff;
  logic [1:0]            r_mode, w_nxt_mode, w_mode;
  logic                  w_adv, w_accept, w_first, w_last;

  logic                  r_vld_p1, r_first_p1, r_last_p1, r_neg_p1;
  logic signed [AW-1:0]  r_a_p1;
  logic signed [BW:0]    r_pre_p1;
  logic                  r_vld_p2, r_first_p2, r_last_p2;
  logic signed [MW-1:0]  r_m_p2, w_prod;
  logic signed [PW-1:0]  r_acc_p3, w_acc_nxt, r_p;
  logic                  r_fovf_p3, w_fovf_nxt, w_ovf, r_ovf, r_out_vld;
  logic signed [PW:0]    w_m_ext, w_acc_ext, w_sum;

  assign w_adv    = bus.CE & (~r_out_vld | bus.out_ready);
  assign w_accept = w_adv & bus.in_valid;

  // Frame tracking: tags first/last beats and holds the per-frame mode.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_len   = r_len;
    w_nxt_mode  = r_mode;
    w_mode      = r_mode;
    w_first     = 1'b0;
    w_last      = 1'b0;
    w_len_eff   = (bus.LEN == '0) ? LEN_W'(1) : bus.LEN;
    if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          w_first    = 1'b1;
          w_mode     = bus.MODE;
          w_nxt_mode = bus.MODE;
          w_nxt_len  = w_len_eff;
          if (w_len_eff == LEN_W'(1)) begin
            w_last = 1'b1;
          end else begin
            w_nxt_state = S_RUN;
            w_nxt_cnt   = LEN_W'(1);
          end
        end
        default: begin
          if (r_cnt + LEN_W'(1) == r_len) begin
            w_last      = 1'b1;
            w_nxt_state = S_IDLE;
            w_nxt_cnt   = '0;
          end else begin
            w_nxt_cnt = r_cnt + LEN_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_mode  <= '0;
    end else if (w_accept) begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_len   <= w_nxt_len;
      r_mode  <= w_nxt_mode;
    end
  end

  assign w_prod     = MW'(r_a_p1) * MW'(r_pre_p1);
  assign w_m_ext    = {{(PW + 1 - MW){r_m_p2[MW-1]}}, r_m_p2};
  assign w_acc_ext  = {r_acc_p3[PW-1], r_acc_p3};
  assign w_sum      = r_first_p2 ? w_m_ext : (w_acc_ext + w_m_ext);
  assign w_ovf      = w_sum[PW] ^ w_sum[PW-1];
  assign w_acc_nxt  = f_sat(w_sum);
  assign w_fovf_nxt = w_ovf | (~r_first_p2 & r_fovf_p3);

  // Stage 1 -> stage 2 -> stage 3 datapath; no reset needed on pure data.
  always_ff @(posedge CLK) begin
    if (w_adv) begin
      r_a_p1   <= bus.A;
      r_pre_p1 <= f_pre(w_mode, bus.B, bus.D);
      r_m_p2   <= r_neg_p1 ? -w_prod : w_prod;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vld_p1   <= 1'b0;
      r_first_p1 <= 1'b0;
      r_last_p1  <= 1'b0;
      r_neg_p1   <= 1'b0;
      r_vld_p2   <= 1'b0;
      r_first_p2 <= 1'b0;
      r_last_p2  <= 1'b0;
      r_acc_p3   <= '0;
      r_fovf_p3  <= 1'b0;
      r_p        <= '0;
      r_ovf      <= 1'b0;
      r_out_vld  <= 1'b0;
    end else if (w_adv) begin
      r_vld_p1   <= w_accept;
      r_first_p1 <= w_first;
      r_last_p1  <= w_last;
      r_neg_p1   <= (w_mode == 2'b11);
      r_vld_p2   <= r_vld_p1;
      r_first_p2 <= r_first_p1;
      r_last_p2  <= r_last_p1;
      if (r_vld_p2) begin
        r_acc_p3  <= w_acc_nxt;
        r_fovf_p3 <= w_fovf_nxt;
      end
      if (r_vld_p2 & r_last_p2) begin
        r_p       <= w_acc_nxt;
        r_ovf     <= w_fovf_nxt;
        r_out_vld <= 1'b1;
      end else if (bus.out_ready) begin
        r_out_vld <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_out_vld;
  assign bus.P         = r_p;
  assign bus.OVF       = r_ovf;
endmodule

// File: tb/tb_dsp_mac_stream.sv
// Bench for dsp_mac_stream: directed scenarios plus randomized traffic scored against
// a frame-level arithmetic model, on a 48-bit wrap and two 40-bit (saturate/wrap) instances.
module tb_dsp_mac_stream;
  logic clk = 1'b0;
  logic rst, ce, in_valid, out_ready;
  logic signed [17:0] a, b, d;
  logic [1:0] mode;
  logic [7:0] len;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dsp_mac_stream_if #(.AW(18), .BW(18), .PW(48), .LEN_W(8)) if0 ();
  dsp_mac_stream_if #(.AW(18), .BW(18), .PW(40), .LEN_W(8)) if1 ();
  dsp_mac_stream_if #(.AW(18), .BW(18), .PW(40), .LEN_W(8)) if2 ();

  assign if0.CE = ce; assign if0.in_valid = in_valid; assign if0.out_ready = out_ready;
  assign if0.A = a; assign if0.B = b; assign if0.D = d; assign if0.MODE = mode; assign if0.LEN = len;
  assign if1.CE = ce; assign if1.in_valid = in_valid; assign if1.out_ready = out_ready;
  assign if1.A = a; assign if1.B = b; assign if1.D = d; assign if1.MODE = mode; assign if1.LEN = len;
  assign if2.CE = ce; assign if2.in_valid = in_valid; assign if2.out_ready = out_ready;
  assign if2.A = a; assign if2.B = b; assign if2.D = d; assign if2.MODE = mode; assign if2.LEN = len;

  dsp_mac_stream #(.AW(18), .BW(18), .PW(48), .LEN_W(8), .SATURATE(1'b0))
    u_dut0 (.CLK(clk), .RST(rst), .bus(if0));
  dsp_mac_stream #(.AW(18), .BW(18), .PW(40), .LEN_W(8), .SATURATE(1'b1))
    u_dut1 (.CLK(clk), .RST(rst), .bus(if1));
  dsp_mac_stream #(.AW(18), .BW(18), .PW(40), .LEN_W(8), .SATURATE(1'b0))
    u_dut2 (.CLK(clk), .RST(rst), .bus(if2));

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Frame-level reference model
  typedef struct {longint p; bit ovf;} res_t;
  res_t   q0[$], q1[$], q2[$];
  longint fa[$], fb[$], fd[$];
  int     fmode, flen;
  bit     infr = 1'b0;

  function automatic res_t model(input int pw, input bit sat);
    res_t   r;
    longint acc, m, pre, maxv, minv, span;
    span  = longint'(1) <<< pw;
    maxv  = (longint'(1) <<< (pw - 1)) - 1;
    minv  = -(longint'(1) <<< (pw - 1));
    acc   = 0;
    r.ovf = 1'b0;
    for (int i = 0; i < fa.size(); i++) begin
      pre = (fmode == 1) ? fd[i] + fb[i] : (fmode == 2) ? fd[i] - fb[i] : fb[i];
      m   = fa[i] * pre;
      if (fmode == 3) m = -m;
      acc = (i == 0) ? m : acc + m;
      if (acc > maxv) begin r.ovf = 1'b1; acc = sat ? maxv : acc - span; end
      if (acc < minv) begin r.ovf = 1'b1; acc = sat ? minv : acc + span; end
    end
    r.p = acc;
    return r;
  endfunction

  task automatic sb_pop(input int k, input longint p, input bit o);
    res_t r;
    int   sz;
    sz = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
    chk($sformatf("sb%0d_nonempty", k), longint'(sz > 0), 1);
    if (sz == 0) return;
    case (k)
      0:       r = q0.pop_front();
      1:       r = q1.pop_front();
      default: r = q2.pop_front();
    endcase
    chk($sformatf("sb%0d_p", k), p, r.p);
    chk($sformatf("sb%0d_ovf", k), longint'(o), longint'(r.ovf));
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q0.delete(); q1.delete(); q2.delete();
      fa.delete(); fb.delete(); fd.delete();
      infr = 1'b0;
    end else begin
      if (ce && out_ready) begin
        if (if0.out_valid) sb_pop(0, if0.P, if0.OVF);
        if (if1.out_valid) sb_pop(1, if1.P, if1.OVF);
        if (if2.out_valid) sb_pop(2, if2.P, if2.OVF);
      end
      if (in_valid && if0.in_ready) begin
        if (!infr) begin
          fa.delete(); fb.delete(); fd.delete();
          fmode = int'(mode);
          flen  = (len == 8'd0) ? 1 : int'(len);
          infr  = 1'b1;
        end
        fa.push_back(a); fb.push_back(b); fd.push_back(d);
        if (fa.size() == flen) begin
          infr = 1'b0;
          q0.push_back(model(48, 1'b0));
          q1.push_back(model(40, 1'b1));
          q2.push_back(model(40, 1'b0));
        end
      end
    end
  end

  task automatic send(input int av, input int bv, input int dv, input int md, input int ln);
    int n = 0;
    in_valid = 1'b1; a = 18'(av); b = 18'(bv); d = 18'(dv); mode = 2'(md); len = 8'(ln);
    @(negedge clk);
    while (!if0.in_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_vld(input string tag);
    int n = 0;
    while (!if0.out_valid && n < 400) begin @(posedge clk); #1; n++; end
    chk({tag, "_vld"}, longint'(if0.out_valid), 1);
  endtask

  task automatic await_out(input string tag, input longint ep, input bit eo);
    wait_vld(tag);
    chk({tag, "_p"}, if0.P, ep);
    chk({tag, "_ovf"}, longint'(if0.OVF), longint'(eo));
    @(posedge clk); #1;
  endtask

  task automatic pre_test(input string tag, input int md, input longint ep);
    send(20, 10, 25, md, 1);
    chk({tag, "_lat0"}, longint'(if0.out_valid), 0);
    @(posedge clk); #1;
    chk({tag, "_lat1"}, longint'(if0.out_valid), 0);
    @(posedge clk); #1;
    chk({tag, "_lat2"}, longint'(if0.out_valid), 1);
    chk({tag, "_p"}, if0.P, ep);
    @(posedge clk); #1;
  endtask

  task automatic run_dot(input int stall);
    logic   ov[16];
    logic   ir[16];
    longint pv[16];
    int av[6] = '{1, 2, 3, 4, -3, 2};
    int bv[6] = '{5, 6, 7, 8, 4, 5};
    for (int i = 0; i < 16; i++) begin
      out_ready = !(i >= 6 && i < 6 + stall);
      #1;
      ov[i] = if0.out_valid; pv[i] = if0.P; ir[i] = if0.in_ready;
      if (i < 6) begin
        in_valid = 1'b1; a = 18'(av[i]); b = 18'(bv[i]); d = '0; mode = 2'b00;
        len = (i < 4) ? 8'd4 : 8'd2;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk("dot_pre", longint'(ov[5]), 0);
    chk("dot1_vld", longint'(ov[6]), 1);
    chk("dot1_p", pv[6], 70);
    for (int i = 6; i < 6 + stall; i++) begin
      chk("bp_inready", longint'(ir[i]), 0);
      chk("bp_hold_p", pv[i], 70);
      chk("bp_hold_vld", longint'(ov[i]), 1);
    end
    chk("dot_gap", longint'(ov[7 + stall]), 0);
    chk("dot2_vld", longint'(ov[8 + stall]), 1);
    chk("dot2_p", pv[8 + stall], -2);
    chk("dot_end", longint'(ov[9 + stall]), 0);
  endtask

  function automatic logic signed [17:0] rnd18();
    case ($urandom_range(0, 7))
      0, 1:    return 18'sh20000;
      2:       return 18'sh1FFFF;
      default: return 18'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1; ce = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    a = 18'sd100; b = 18'sd200; d = 18'sd400; mode = 2'b00; len = 8'd1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst_vld", longint'(if0.out_valid), 0);
      chk("rst_p", if0.P, 0);
      chk("rst_ovf", longint'(if0.OVF), 0);
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_inready", longint'(if0.in_ready), 1);
    @(posedge clk); #1;

    pre_test("pre_add", 1, 700);
    pre_test("pre_sub", 2, 300);
    pre_test("pre_neg", 3, -200);

    run_dot(0);
    @(posedge clk); #1;
    run_dot(5);
    out_ready = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 64; i++) send(-131072, -131072, 0, 0, 64);
    wait_vld("sat");
    chk("sat1_p", if1.P, 40'sh7F_FFFF_FFFF);
    chk("sat1_ovf", longint'(if1.OVF), 1);
    chk("wrap2_p", if2.P, 0);
    chk("wrap2_ovf", longint'(if2.OVF), 1);
    chk("wide0_p", if0.P, longint'(1) <<< 40);
    chk("wide0_ovf", longint'(if0.OVF), 0);
    @(posedge clk); #1;

    send(5, 6, 0, 0, 0);
    await_out("len0", 30, 1'b0);

    send(2, 3, 0, 0, 1);
    ce = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("ce_inready", longint'(if0.in_ready), 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("ce_freeze", longint'(if0.out_valid), 0);
    end
    in_valid = 1'b0; ce = 1'b1;
    await_out("ce_resume", 6, 1'b0);

    send(1, 1, 1, 0, 4);
    send(1, 1, 1, 0, 4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 8; i++) begin
        if (if0.out_valid) seen++;
        @(posedge clk); #1;
      end
      chk("rstmid_novld", seen, 0);
    end
    send(3, 3, 0, 0, 1);
    await_out("rstmid_next", 9, 1'b0);

    for (int c = 0; c < 3000; c++) begin
      ce        = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 599) == 0);
      mode      = 2'($urandom);
      len       = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 7) == 0) len = 8'($urandom_range(20, 64));
      a = rnd18(); b = rnd18(); d = rnd18();
      @(posedge clk); #1;
    end
    rst = 1'b0; ce = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("drain0", q0.size(), 0);
    chk("drain1", q1.size(), 0);
    chk("drain2", q2.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dsp_mac_stream.md
# dsp_mac_stream

Parametrised, streaming multiply-accumulate engine built on the DSP48A1 datapath style. It has a registered pre-adder, a pipelined multiplier and a post-accumulator. It reduces frames of LEN operand beats into one dot-product result. Unlike the fixed-width, free-running slice, it adds:
- generic operand and accumulator widths,
- per-frame mode and length,
- a valid/ready handshake with full-pipeline backpressure,
- optional saturation with an overflow flag.

It sits between operand-fetch logic and result consumers in the filter/correlator datapath.

## Interface
- AW, 18, signed width of A
- BW, 18, signed width of B and D
- PW, 48, signed accumulator/result width; must be ≥ AW+BW+1
- LEN_W, 8, width of the frame-length field
- SATURATE, 0, 1 = clamp accumulator on overflow; 0 = two's-complement wrap
- CLK  in  1  single clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- CE  in  1  global clock enable; 0 freezes all state
- in_valid  in  1  operand beat valid
- in_ready  out  1  beat accepted on an edge where in_valid & in_ready
- A  in  AW  signed multiplicand
- B  in  BW  signed operand
- D  in  BW  signed pre-adder operand
- MODE  in  2  00: A·B, 01: A·(D+B), 10: A·(D−B), 11: −(A·B); sampled on the first beat of a frame
- LEN  in  LEN_W  beats per frame; sampled on the first beat; 0 is treated as 1
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- P  out  PW  signed dot-product result
- OVF  out  1  accumulator overflowed at least once during the frame of the current P

## Operation
- Advance signal: adv = CE & (~out_valid | out_ready).
  - in_ready = adv (combinational).
  - Every pipeline register moves only when adv = 1. Stalls freeze the whole pipe, so no beat is lost or duplicated.
- Input FSM:
  - IDLE: first accepted beat latches MODE and LEN, and tags the beat first. If the effective LEN = 1, the beat is also tagged last and the FSM stays in IDLE. Otherwise the FSM goes to RUN with cnt = 1.
  - RUN: each accepted beat increments cnt. The beat where cnt+1 = LEN is tagged last, and the FSM returns to IDLE with cnt = 0.
  - Cycles without an accepted beat insert a bubble: the valid bit travels through the pipe as 0.
- Stage 1 (S1):
  - Register A.
  - Register pre-adder output PRE (BW+1 bits, sign-extended): B, D+B, D−B or B according to the frame MODE.
  - Register valid, first, last and the negate flag.
- Stage 2 (M): M = A·PRE, AW+BW+1 bits signed; negated when MODE = 11. Flags are carried along.
- Stage 3 (ACC): computed in PW+1 bits, sign-extending M to PW.
  - first beat: ACC = M.
  - other beats: ACC = ACC + M.
  - Overflow = the PW+1 sum is not representable in PW bits.
  - SATURATE = 1: clamp to 2^(PW−1)−1 or −2^(PW−1).
  - SATURATE = 0: keep the low PW bits.
  - The frame overflow flag is set on overflow and cleared on the first beat.
- Output: when a last beat reaches stage 3, P ← final ACC, OVF ← frame flag, out_valid ← 1. out_valid clears on an edge with out_ready & ~(new result).
- Back-to-back frames are supported: a new first beat may directly follow a last beat.

## Timing
- Latency: a beat accepted on edge t is in S1 after t, in M after t+1 and in ACC after t+2.
  - A last beat accepted on edge t gives out_valid = 1 after edge t+2, with P valid.
  - Full throughput is one beat per cycle when out_ready = 1.
- P and OVF hold stable while out_valid & ~out_ready.
- RST (sampled high at an edge, regardless of CE) clears:
  - every valid/first/last bit, and ACC, cnt and the frame flag;
  - FSM → IDLE, P = 0, OVF = 0, out_valid = 0.
- After reset, in_ready = CE.
- Reset mid-frame discards the partial frame and any in-flight beats; no out_valid is produced for that frame.
- CE = 0 with RST = 0: all state holds and in_ready = 0.

## Test plan
- Reset: RST = 1 for 2 cycles with in_valid = 1, A = 100, B = 200, D = 400 → out_valid = 0, P = 0, OVF = 0; in_ready = 1 in the first cycle after RST drops.
- Pre-adder: LEN = 1 with A = 20, B = 10, D = 25.
  - MODE = 01 → P = 700 (0x2BC), out_valid exactly 2 edges after accept.
  - MODE = 10 → P = 300 (0x12C).
  - MODE = 11 → P = −200.
- Dot product, back-to-back frames:
  - LEN = 4, MODE = 00, A = {1,2,3,4}, B = {5,6,7,8} → P = 70.
  - Immediately after, LEN = 2, A = {−3,2}, B = {4,5} → P = −2 (all ones except LSB = 0).
  - Two single-cycle out_valid pulses, with out_ready = 1.
- Backpressure: repeat the previous scenario with out_ready = 0 for 5 cycles after the first result → P holds 70, in_ready = 0 throughout, then P = −2 after release, with no lost beats.
- Saturation: PW = 40, SATURATE = 1, LEN = 64, MODE = 00, A = B = −131072 each beat.
  - Result: P = 0x7F_FFFF_FFFF, OVF = 1.
  - With SATURATE = 0: P = 0, OVF = 1.
- Reset mid-frame:
  - LEN = 4, accept 2 beats, then pulse RST for 1 cycle → no out_valid.
  - Next frame LEN = 1, A = 3, B = 3, MODE = 00 → P = 9, OVF = 0.
